axi_rd_slave_mem_addr16_data8_id4: RTL

AXI4 read-only subordinate that serves AR/R bursts from an internal byte memory. It is the responder counterpart to the axi_dma_addr16_data8_id4 read initiator. It replaces behavioural memory models in benches and acts as a boot/ROM-style source in SoC builds. A side write port preloads the memory and is not AXI.

---
 rtl/axi_pkg.sv | 49 ++++
 rtl/sync_ram_1r1w.sv | 35 +++
 rtl/axi_rd_slave_mem_addr16_data8_id4.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-side types, response codes and the burst address-advance helper.
package axi_pkg;

    localparam int unsigned AXI_ADDR_W  = 16;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_BEATS_W = 9;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [1:0]            burst;
    } axi_ar_t;

    // WRAP is honoured only for 2/4/8/16 beats; other lengths and the reserved code behave as INCR.
    function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(
        input logic [AXI_ADDR_W-1:0]  addr,
        input logic [AXI_BEATS_W-1:0] beats,
        input logic [1:0]             burst
    );
        logic [AXI_ADDR_W-1:0] mask;
        logic                  wrap_ok;
        mask    = AXI_ADDR_W'(beats) - AXI_ADDR_W'(1);
        wrap_ok = (burst == AXI_BURST_WRAP) &&
                  (beats == 9'd2 || beats == 9'd4 || beats == 9'd8 || beats == 9'd16);
        if (burst == AXI_BURST_FIXED) begin
            return addr;
        end else if (wrap_ok) begin
            return (addr & ~mask) | ((addr + AXI_ADDR_W'(1)) & mask);
        end else begin
            return addr + AXI_ADDR_W'(1);
        end
    endfunction

endpackage

// File: rtl/sync_ram_1r1w.sv
// Byte-array RAM with one write port and one registered read port (read-before-write).
module sync_ram_1r1w #(
    parameter int unsigned DEPTH = 65536,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             rclr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rclr lets the owner return zero data for error beats without an output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/axi_rd_slave_mem_addr16_data8_id4.sv
// AXI4 read-only subordinate serving byte bursts from an internal preloadable memory.
// Optional macro AXI_RD_SLAVE_ERR_EN: SLVERR for out-of-range beats and bursts with arsize != 0.
module axi_rd_slave_mem_addr16_data8_id4
    import axi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 65536,
    parameter int unsigned ID_W      = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            axi_arvalid,
    output logic            axi_arready,
    input  logic [ID_W-1:0] axi_arid,
    input  logic [15:0]     axi_araddr,
    input  logic [7:0]      axi_arlen,
    input  logic [1:0]      axi_arsize,
    input  logic [1:0]      axi_arburst,
    output logic            axi_rvalid,
    input  logic            axi_rready,
    output logic [ID_W-1:0] axi_rid,
    output logic [7:0]      axi_rdata,
    output logic [1:0]      axi_rresp,
    output logic            axi_rlast,
    input  logic            mem_we,
    input  logic [15:0]     mem_waddr,
    input  logic [7:0]      mem_wdata
);

    localparam int unsigned RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    rd_state_e       state_q, state_d;
    axi_ar_t         req_q, req_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [8:0]      beat_q, beat_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic            ram_re, ram_clr, ram_we;
    logic            beat_err;

`ifdef AXI_RD_SLAVE_ERR_EN
    logic serr_q, serr_d;
    assign beat_err = serr_q || (32'(req_q.addr) >= MEM_DEPTH);
`else
    logic unused_arsize;
    assign unused_arsize = ^axi_arsize;
    assign beat_err      = 1'b0;
`endif

    assign ram_we = mem_we && (32'(mem_waddr) < MEM_DEPTH);

    sync_ram_1r1w #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (8),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (nreset),
        .we    (ram_we),
        .waddr (mem_waddr[RAM_AW-1:0]),
        .wdata (mem_wdata),
        .re    (ram_re),
        .rclr  (ram_clr),
        .raddr (req_q.addr[RAM_AW-1:0]),
        .rdata (axi_rdata)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        id_d      = id_q;
        beat_d    = beat_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ram_re    = 1'b0;
        ram_clr   = 1'b0;
`ifdef AXI_RD_SLAVE_ERR_EN
        serr_d    = serr_q;
`endif
        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (axi_arvalid && arready_q) begin
                    req_d.addr  = axi_araddr;
                    req_d.len   = axi_arlen;
                    req_d.burst = axi_arburst;
                    id_d        = axi_arid;
                    beat_d      = '0;
                    arready_d   = 1'b0;
                    state_d     = FETCH;
`ifdef AXI_RD_SLAVE_ERR_EN
                    serr_d      = (axi_arsize != 2'd0);
`endif
                end
            end
            FETCH: begin
                ram_re   = 1'b1;
                ram_clr  = beat_err;
                rvalid_d = 1'b1;
                rresp_d  = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                rlast_d  = (beat_q == 9'(req_q.len));
                state_d  = SEND;
            end
            SEND: begin
                if (axi_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    rresp_d  = AXI_RESP_OKAY;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        req_d.addr = axi_next_addr(req_q.addr, 9'(req_q.len) + 9'd1, req_q.burst);
                        beat_d     = beat_q + 9'd1;
                        state_d    = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            id_q      <= '0;
            beat_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
            rlast_q   <= 1'b0;
`ifdef AXI_RD_SLAVE_ERR_EN
            serr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            id_q      <= id_d;
            beat_q    <= beat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
`ifdef AXI_RD_SLAVE_ERR_EN
            serr_q    <= serr_d;
`endif
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rid     = id_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;

endmodule
